pool_window_row: RTL and testbench



---
 rtl/pool_window_row.sv | 170 +++++++++++++++++
 tb/tb_pool_window_row.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_row.sv
// -----------------------------------------------------------------------------
// pool_window_row
//
// Row-streaming pooling datapath. Whole rows of ACT_BITS-wide activations come
// in over a valid/ready handshake. Each KER_SIZE x KER_SIZE window is reduced by
// max (MAX_N_AVG=1) or average (MAX_N_AVG=0). One pooled row goes out per
// KER_SIZE input rows, or earlier when in_last closes a partial window.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   flush      (only with POOL_WINDOW_FLUSH_EN) drop the partial window
//   in_valid   input row valid
//   in_ready   block accepts a row this cycle
//   in_data    input row, column c at [c*ACT_BITS +: ACT_BITS]
//   in_last    row is the last of the frame
//   out_valid  pooled row valid
//   out_ready  downstream accepts pooled row
//   out_data   pooled row, same packing as in_data
//   out_last   pooled row closes the frame
//
// Optional feature macro: POOL_WINDOW_FLUSH_EN (adds the flush input).
// -----------------------------------------------------------------------------
module pool_window_row #(
    parameter int ACT_BITS  = 3,
    parameter int KER_SIZE  = 2,
    parameter int IN_WIDTH  = 28,
    parameter int MAX_N_AVG = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
`ifdef POOL_WINDOW_FLUSH_EN
    input  logic                                     flush,
`endif
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [IN_WIDTH*ACT_BITS-1:0]             in_data,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [(IN_WIDTH/KER_SIZE)*ACT_BITS-1:0]  out_data,
    output logic                                     out_last
);

    localparam int OUT_WIDTH = IN_WIDTH / KER_SIZE;
    localparam int LOG2K     = $clog2(KER_SIZE);
    localparam int CNT_W     = LOG2K;
    // Average mode keeps the full sum of KER_SIZE^2 values, so no overflow.
    localparam int ACC_W     = (MAX_N_AVG != 0) ? ACT_BITS : ACT_BITS + 2 * LOG2K;

    // Reject configurations the column grouping and shift-divide cannot serve.
    generate
        if ((IN_WIDTH % KER_SIZE) != 0 || KER_SIZE < 2 ||
            (KER_SIZE & (KER_SIZE - 1)) != 0) begin : g_bad_cfg
            $error("pool_window_row: IN_WIDTH must be a multiple of KER_SIZE and KER_SIZE a power of two >= 2");
        end
    endgenerate

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t                         out_state;
    logic [CNT_W-1:0]                   cnt;
    logic [OUT_WIDTH-1:0][ACC_W-1:0]    acc;
    logic [OUT_WIDTH-1:0][ACC_W-1:0]    horiz;
    logic [OUT_WIDTH-1:0][ACC_W-1:0]    combined;
    logic [OUT_WIDTH*ACT_BITS-1:0]      pooled;
    logic                               flush_req;
    logic                               in_accept;
    logic                               win_close;

`ifdef POOL_WINDOW_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // The output register can take a new row whenever it is empty or being
    // drained this same cycle; a flush cycle refuses input so nothing slips in.
    assign out_valid = (out_state == OUT_FULL);
    assign in_ready  = (!out_valid || out_ready) && !flush_req;
    assign in_accept = in_valid && in_ready;
    assign win_close = (cnt == CNT_W'(KER_SIZE - 1)) || in_last;

    // Horizontal reduction and vertical combine. The first row of a window
    // (cnt==0) seeds the result directly so the stale accumulator is ignored.
    generate
        if (MAX_N_AVG != 0) begin : g_max
            always_comb begin
                horiz = '0;
                for (int j = 0; j < OUT_WIDTH; j++) begin
                    for (int k = 0; k < KER_SIZE; k++) begin
                        if (ACC_W'(in_data[(j*KER_SIZE+k)*ACT_BITS +: ACT_BITS]) > horiz[j]) begin
                            horiz[j] = ACC_W'(in_data[(j*KER_SIZE+k)*ACT_BITS +: ACT_BITS]);
                        end
                    end
                end
            end

            always_comb begin
                combined = '0;
                for (int j = 0; j < OUT_WIDTH; j++) begin
                    combined[j] = (cnt == '0 || horiz[j] > acc[j]) ? horiz[j] : acc[j];
                end
            end
        end else begin : g_avg
            always_comb begin
                horiz = '0;
                for (int j = 0; j < OUT_WIDTH; j++) begin
                    for (int k = 0; k < KER_SIZE; k++) begin
                        horiz[j] = horiz[j] + ACC_W'(in_data[(j*KER_SIZE+k)*ACT_BITS +: ACT_BITS]);
                    end
                end
            end

            always_comb begin
                combined = '0;
                for (int j = 0; j < OUT_WIDTH; j++) begin
                    combined[j] = (cnt == '0) ? horiz[j] : acc[j] + horiz[j];
                end
            end
        end
    endgenerate

    // Taking the top ACT_BITS of each lane is the divide by KER_SIZE^2 in
    // average mode (missing rows simply contributed zero) and a plain copy in
    // max mode, where the lane is exactly ACT_BITS wide.
    always_comb begin
        pooled = '0;
        for (int j = 0; j < OUT_WIDTH; j++) begin
            pooled[j*ACT_BITS +: ACT_BITS] = combined[j][ACC_W-1 -: ACT_BITS];
        end
    end

    // Row counter, accumulator and output register. A consume and a closing
    // accept in the same cycle let the new row overwrite the old one, so
    // out_valid stays high without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_state <= OUT_EMPTY;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_state <= OUT_EMPTY;
                out_last  <= 1'b0;
            end
            if (flush_req) begin
                cnt <= '0;
                acc <= '0;
            end else if (in_accept) begin
                if (win_close) begin
                    out_data  <= pooled;
                    out_last  <= in_last;
                    out_state <= OUT_FULL;
                    cnt       <= '0;
                    acc       <= '0;
                end else begin
                    acc <= combined;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_row.sv
// -----------------------------------------------------------------------------
// tb_pool_window_row
//
// Drives one max-mode and one average-mode pool_window_row (KER_SIZE=2,
// IN_WIDTH=4, ACT_BITS=3) from a shared row stream. Closed windows are pushed
// to per-mode expectation queues and compared while the pooled row is held.
// -----------------------------------------------------------------------------
module tb_pool_window_row;

    localparam int A  = 3;
    localparam int K  = 2;
    localparam int IW = 4;
    localparam int OW = IW / K;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_last;
    logic            out_ready;
    logic            flush;
    logic [IW*A-1:0] in_data;

    logic            mx_in_ready, mx_out_valid, mx_out_last;
    logic [OW*A-1:0] mx_out_data;
    logic            av_in_ready, av_out_valid, av_out_last;
    logic [OW*A-1:0] av_out_data;

    int checks = 0;
    int errors = 0;

    logic [OW*A:0]   exp_max[$];
    logic [OW*A:0]   exp_avg[$];
    logic [IW*A-1:0] win_rows [K];
    int              win_cnt = 0;
    bit              accepted;

    always #5 clk = ~clk;

    pool_window_row #(.ACT_BITS(A), .KER_SIZE(K), .IN_WIDTH(IW), .MAX_N_AVG(1)) u_max (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef POOL_WINDOW_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (mx_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (mx_out_valid),
        .out_ready (out_ready),
        .out_data  (mx_out_data),
        .out_last  (mx_out_last)
    );

    pool_window_row #(.ACT_BITS(A), .KER_SIZE(K), .IN_WIDTH(IW), .MAX_N_AVG(0)) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef POOL_WINDOW_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (av_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (av_out_valid),
        .out_ready (out_ready),
        .out_data  (av_out_data),
        .out_last  (av_out_last)
    );

    // One comparison point: count it, and on mismatch count and report.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [IW*A-1:0] mkRow(input int c0, input int c1, input int c2, input int c3);
        logic [IW*A-1:0] r;
        r = '0;
        r[0*A +: A] = A'(c0);
        r[1*A +: A] = A'(c1);
        r[2*A +: A] = A'(c2);
        r[3*A +: A] = A'(c3);
        return r;
    endfunction

    // Reference reduction over the rows gathered in the model window.
    task automatic closeWindow(input logic last);
        logic [OW*A-1:0] md;
        logic [OW*A-1:0] ad;
        logic [A-1:0]    v;
        logic [A-1:0]    mx;
        int              sm;
        md = '0;
        ad = '0;
        for (int j = 0; j < OW; j++) begin
            mx = '0;
            sm = 0;
            for (int r = 0; r < win_cnt; r++) begin
                for (int k = 0; k < K; k++) begin
                    v = win_rows[r][(j*K+k)*A +: A];
                    if (v > mx) mx = v;
                    sm += int'(v);
                end
            end
            md[j*A +: A] = mx;
            ad[j*A +: A] = A'(sm / (K*K));
        end
        exp_max.push_back({last, md});
        exp_avg.push_back({last, ad});
        win_cnt = 0;
    endtask

    // Per-cycle output comparison against the scoreboard heads.
    task automatic checkOutput();
        logic pend_m, pend_a, exp_ready;
        pend_m    = (exp_max.size() != 0);
        pend_a    = (exp_avg.size() != 0);
        exp_ready = (!pend_m || out_ready) && !flush;
        checkVal("mx_out_valid", 32'(mx_out_valid), 32'(pend_m));
        checkVal("av_out_valid", 32'(av_out_valid), 32'(pend_a));
        checkVal("mx_in_ready", 32'(mx_in_ready), 32'(exp_ready));
        checkVal("av_in_ready", 32'(av_in_ready), 32'(exp_ready));
        if (pend_m) begin
            checkVal("mx_out_data", 32'(mx_out_data), 32'(exp_max[0][OW*A-1:0]));
            checkVal("mx_out_last", 32'(mx_out_last), 32'(exp_max[0][OW*A]));
        end
        if (pend_a) begin
            checkVal("av_out_data", 32'(av_out_data), 32'(exp_avg[0][OW*A-1:0]));
            checkVal("av_out_last", 32'(av_out_last), 32'(exp_avg[0][OW*A]));
        end
    endtask

    // One clock: sample/check at the falling edge, update the model after the
    // rising edge, leave inputs free to change #1 after it.
    task automatic cycle();
        bit              acc_now, cons_now, flush_now;
        logic            lastv;
        logic [IW*A-1:0] row;
        @(negedge clk);
        checkOutput();
        cons_now  = (exp_max.size() != 0) && out_ready && rst_n;
        acc_now   = in_valid && ((exp_max.size() == 0) || out_ready) && !flush && rst_n;
        flush_now = flush && rst_n;
        row       = in_data;
        lastv     = in_last;
        @(posedge clk);
        #1;
        if (cons_now) begin
            exp_max.delete(0);
            exp_avg.delete(0);
        end
        if (flush_now) win_cnt = 0;
        if (acc_now) begin
            win_rows[win_cnt] = row;
            win_cnt++;
            if (win_cnt == K || lastv) closeWindow(lastv);
        end
        accepted = acc_now;
    endtask

    task automatic applyStimulus(input logic [IW*A-1:0] row, input logic last);
        in_data  = row;
        in_last  = last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (accepted) break;
        end
        checkVal("accept_timeout", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic assertReset();
        rst_n = 1'b0;
        exp_max.delete();
        exp_avg.delete();
        win_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;

        // Reset values
        #1;
        checkVal("rst_mx_out_valid", 32'(mx_out_valid), 32'd0);
        checkVal("rst_mx_out_last", 32'(mx_out_last), 32'd0);
        checkVal("rst_mx_out_data", 32'(mx_out_data), 32'd0);
        checkVal("rst_av_out_data", 32'(av_out_data), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        $display("[TB] reset released");

        // Basic 2x2 window, full rate
        applyStimulus(mkRow(1, 5, 2, 3), 1'b0);
        applyStimulus(mkRow(4, 0, 7, 6), 1'b0);
        repeat (2) cycle();

        // Saturated values, checks accumulator width in average mode
        applyStimulus(mkRow(7, 7, 7, 7), 1'b0);
        applyStimulus(mkRow(7, 7, 7, 7), 1'b0);
        repeat (2) cycle();

        // Backpressure: pooled row pending, input held off for 5 cycles
        out_ready = 1'b0;
        applyStimulus(mkRow(3, 1, 0, 6), 1'b0);
        applyStimulus(mkRow(2, 4, 5, 1), 1'b0);
        in_data  = mkRow(6, 6, 1, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkVal("bp_no_accept", 32'(accepted), 32'd0);
        end
        out_ready = 1'b1;
        applyStimulus(mkRow(6, 6, 1, 1), 1'b0);
        applyStimulus(mkRow(0, 2, 4, 3), 1'b0);
        repeat (2) cycle();

        // Odd frame height: in_last closes a partial window
        applyStimulus(mkRow(1, 1, 1, 1), 1'b0);
        applyStimulus(mkRow(2, 2, 2, 2), 1'b0);
        applyStimulus(mkRow(3, 0, 0, 3), 1'b1);
        repeat (2) cycle();

        // Single-row windows back to back: accept and consume in one cycle
        applyStimulus(mkRow(1, 2, 3, 4), 1'b1);
        applyStimulus(mkRow(5, 6, 7, 0), 1'b1);
        applyStimulus(mkRow(3, 3, 1, 1), 1'b1);
        repeat (2) cycle();

        // Asynchronous reset clears a pending output without a clock edge
        out_ready = 1'b0;
        applyStimulus(mkRow(4, 4, 4, 4), 1'b0);
        applyStimulus(mkRow(5, 5, 5, 5), 1'b0);
        cycle();
        assertReset();
        #1;
        checkVal("async_mx_out_valid", 32'(mx_out_valid), 32'd0);
        checkVal("async_av_out_valid", 32'(av_out_valid), 32'd0);
        checkVal("async_mx_out_data", 32'(mx_out_data), 32'd0);
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Reset mid-window discards the partial accumulation
        applyStimulus(mkRow(7, 7, 7, 7), 1'b0);
        assertReset();
        cycle();
        rst_n = 1'b1;
        applyStimulus(mkRow(0, 0, 0, 0), 1'b0);
        applyStimulus(mkRow(1, 2, 3, 4), 1'b0);
        repeat (2) cycle();

`ifdef POOL_WINDOW_FLUSH_EN
        // Flush drops the partial window and the row offered alongside it
        applyStimulus(mkRow(7, 7, 7, 7), 1'b0);
        in_data  = mkRow(7, 7, 7, 7);
        in_valid = 1'b1;
        flush    = 1'b1;
        cycle();
        checkVal("flush_drop", 32'(accepted), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        applyStimulus(mkRow(1, 0, 0, 1), 1'b0);
        applyStimulus(mkRow(0, 1, 1, 0), 1'b0);
        repeat (2) cycle();
`endif

        repeat (3) cycle();
        checkVal("queue_drained", 32'(exp_max.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
